digit_stream_sequencer: RTL and testbench
=========================================

// Module: digit_stream_sequencer
// PURPOSE
//  Source end of the pixel-correlation interface used by the digit recogniser's max-correlation tracker.
//  On start, reads the captured image and each of NUM_REFS stored reference templates from synchronous-read memories.
//  Streams byte pairs as current/reference with temp=1, and inserts one temp=0 compare cycle per template, carrying that template's index.
//  Sits between the image/template RAMs and the tracker; pulses done once every template has been compared.
// PARAMETERS
//  PIXELS    64   pixels per image/template (>=2)
//  NUM_REFS  10   number of reference templates (1..16, index is 4 bits)
//  IMG_AW    6    image RAM address width, 2**IMG_AW >= PIXELS
//  REF_AW    10   template RAM address width, 2**REF_AW >= NUM_REFS*PIXELS
// PORTS
//  clock      in   1       single clock, all logic on posedge
//  reset      in   1       synchronous, active-high
//  start      in   1       begin a recognition pass; sampled only in IDLE
//  busy       out  1       high from first address cycle through done cycle
//  done       out  1       one-cycle pulse, pass complete
//  img_rd     out  1       image RAM read enable
//  img_addr   out  IMG_AW  image RAM address = pixel number
//  img_data   in   8       image RAM data, valid 1 cycle after img_rd
//  ref_rd     out  1       template RAM read enable
//  ref_addr   out  REF_AW  template RAM address = ref*PIXELS + pixel
//  ref_data   in   8       template RAM data, valid 1 cycle after ref_rd
//  current    out  8       image pixel to tracker (registered)
//  reference  out  8       template pixel to tracker (registered)
//  temp       out  1       1 = accumulate beat, 0 = compare/clear cycle
//  index      out  4       template number of the latest beat; held through compare cycle
// BEHAVIOUR
//  Reset values:
//   - all outputs 0; state IDLE; pixel and ref counters 0; pipeline valid bits 0.
//   - Reset mid-pass aborts immediately, with no done pulse. temp=0 afterwards clears the tracker sum.
//  FSM:
//   - IDLE -> RUN on start.
//   - RUN issues one read pair per cycle (img_rd=ref_rd=1) for pixel 0..PIXELS-1.
//   - After pixel PIXELS-1: RUN -> GAP.
//   - GAP is one bubble cycle with no reads. If ref<NUM_REFS-1: ref++, pixel=0, back to RUN. Else -> DRAIN.
//   - DRAIN waits until the pipeline is empty and the final temp=0 cycle has been driven.
//   - DRAIN then asserts done for one cycle -> IDLE.
//  Pipeline, 2 stages:
//   - Issue cycle t: RAM data in cycle t+1.
//   - current, reference <= img_data, ref_data at end of t+1, so they are valid in t+2 with temp=1.
//   - Ref tag travels with each beat. index <= tag when a beat reaches the output; it is unchanged otherwise.
//   - Bubble cycles drive temp=0. current/reference hold their last value (don't-care).
//  Timing, with start sampled at edge 0 and P=PIXELS:
//   - ref r beats occupy cycles 3+r(P+1) .. 2+r(P+1)+P.
//   - each is followed by exactly one temp=0 cycle with index=r.
//   - last compare cycle is 2+NUM_REFS*(P+1); done is in the cycle after it.
//   - busy is high from cycle 1 through the done cycle inclusive.
//  Other rules:
//   - Never two consecutive compare cycles inside a pass; never temp=0 between beats of one template.
//   - start while busy: ignored. start held high: a new pass begins on the cycle after done.
//   - Address arithmetic is modulo 2**REF_AW and 2**IMG_AW; parameter legality is checked at elaboration, not run time.
//   - In IDLE: temp=0, img_rd=ref_rd=0, index holds its last value.
// TESTING
//  1 Defaults, image = template 7 (others random), start at edge 0:
//    -> temp pattern is 64x1, 1x0, repeated 10 times. The tracker ends with output1=7, done in cycle 653.
//  2 Byte ramp, img=pixel number, template byte = ref+pixel: check every beat's current/reference/index against the address model.
//  3 Pulse start during busy (cycles 100 and 400) -> no effect, one done only.
//  4 Assert reset in cycle 200 -> all outputs 0 next cycle, no done; a fresh start runs a full 653-cycle pass correctly.
//  5 PIXELS=2, NUM_REFS=1 -> beats in cycles 3-4, temp=0 with index=0 in cycle 5, done in cycle 6.
//  6 start tied high -> back-to-back passes; the second pass's first address is issued in the cycle after done.

Source files
------------

// File: rtl/digit_stream_sequencer.sv
// digit_stream_sequencer
//   Source end of the pixel-correlation interface feeding the digit
//   recogniser's max-correlation tracker. On start it walks the captured
//   image against each of NUM_REFS stored templates. It streams byte pairs
//   (current/reference) with temp=1 and inserts one temp=0 compare cycle
//   after every template, carrying that template's index. done pulses once
//   all templates have been compared.
//
// Ports
//   clock, reset          single clock; synchronous active-high reset
//   start                 begin a pass (sampled only while idle)
//   busy, done            pass in progress / one-cycle completion pulse
//   img_rd, img_addr      image RAM read port (address = pixel number)
//   img_data              image RAM data, valid one cycle after img_rd
//   ref_rd, ref_addr      template RAM read port (address = ref*PIXELS + pixel)
//   ref_data              template RAM data, valid one cycle after ref_rd
//   current, reference    registered pixel pair to the tracker
//   temp                  1 = accumulate beat, 0 = compare/clear cycle
//   index                 template number of the latest beat
module digit_stream_sequencer #(
   parameter int PIXELS   = 64,
   parameter int NUM_REFS = 10,
   parameter int IMG_AW   = 6,
   parameter int REF_AW   = 10
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              img_rd,
   output logic [IMG_AW-1:0] img_addr,
   input  logic [7:0]        img_data,
   output logic              ref_rd,
   output logic [REF_AW-1:0] ref_addr,
   input  logic [7:0]        ref_data,
   output logic [7:0]        current,
   output logic [7:0]        reference,
   output logic              temp,
   output logic [3:0]        index
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] GAP   = 2'd2;
   localparam logic [1:0] DRAIN = 2'd3;

   localparam logic [IMG_AW-1:0] LAST_PIX = IMG_AW'(PIXELS - 1);
   localparam logic [3:0]        LAST_REF = 4'(NUM_REFS - 1);
   localparam logic [REF_AW-1:0] PIX_STEP = REF_AW'(PIXELS);

   generate
      if (PIXELS < 2 || NUM_REFS < 1 || NUM_REFS > 16 ||
          (2 ** IMG_AW) < PIXELS || (2 ** REF_AW) < NUM_REFS * PIXELS) begin : g_param_check
         $error("digit_stream_sequencer: illegal parameter combination");
      end
   endgenerate

   logic [1:0]        state_q, state_d;
   logic [IMG_AW-1:0] pixel_q, pixel_d;
   logic [3:0]        ref_q, ref_d;
   // Running ref*PIXELS, kept incrementally so no multiplier is needed.
   logic [REF_AW-1:0] ref_base_q, ref_base_d;
   logic              v1_q, v1_d;         // a read was issued last cycle
   logic [3:0]        tag1_q, tag1_d;     // template number of that read
   logic [7:0]        current_q, current_d;
   logic [7:0]        reference_q, reference_d;
   logic              temp_q, temp_d;
   logic [3:0]        index_q, index_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
   logic              issue;

   assign issue = (state_q == RUN);

   always_comb begin
      state_d    = state_q;
      pixel_d    = pixel_q;
      ref_d      = ref_q;
      ref_base_d = ref_base_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = RUN;
               pixel_d    = '0;
               ref_d      = '0;
               ref_base_d = '0;
            end
         end
         RUN: begin
            if (pixel_q == LAST_PIX) begin
               pixel_d = '0;
               state_d = GAP;
            end else begin
               pixel_d = pixel_q + IMG_AW'(1);
            end
         end
         GAP: begin
            if (ref_q != LAST_REF) begin
               ref_d      = ref_q + 4'd1;
               ref_base_d = ref_base_q + PIX_STEP;
               state_d    = RUN;
            end else begin
               state_d = DRAIN;
            end
         end
         default: begin
            // Nothing left in flight and the final compare cycle is on the
            // outputs right now: pulse done next cycle.
            if (!v1_q && !temp_q) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
      endcase
   end

   // Two-stage pipeline: RAM latency, then output register. The template
   // tag rides alongside so index always names the beat being presented.
   always_comb begin
      v1_d        = issue;
      tag1_d      = ref_q;
      temp_d      = v1_q;
      current_d   = current_q;
      reference_d = reference_q;
      index_d     = index_q;
      if (v1_q) begin
         current_d   = img_data;
         reference_d = ref_data;
         index_d     = tag1_q;
      end
      busy_d = (state_d != IDLE) || done_d;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         pixel_q     <= '0;
         ref_q       <= '0;
         ref_base_q  <= '0;
         v1_q        <= 1'b0;
         tag1_q      <= '0;
         current_q   <= '0;
         reference_q <= '0;
         temp_q      <= 1'b0;
         index_q     <= '0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pixel_q     <= pixel_d;
         ref_q       <= ref_d;
         ref_base_q  <= ref_base_d;
         v1_q        <= v1_d;
         tag1_q      <= tag1_d;
         current_q   <= current_d;
         reference_q <= reference_d;
         temp_q      <= temp_d;
         index_q     <= index_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign img_rd    = issue;
   assign ref_rd    = issue;
   assign img_addr  = pixel_q;
   assign ref_addr  = ref_base_q + REF_AW'(pixel_q);
   assign current   = current_q;
   assign reference = reference_q;
   assign temp      = temp_q;
   assign index     = index_q;

endmodule

// File: tb/tb_digit_stream_sequencer.sv
// Testbench for digit_stream_sequencer: a default-size instance with image
// and template RAM models, plus a PIXELS=2 / NUM_REFS=1 instance for the
// minimum-size timing case. Expected streams are derived from the cycle
// formulas of the interface (beats, compare cycles, done) and from the
// contents of the bench-owned memories.
module tb_digit_stream_sequencer;

   localparam int P  = 64;
   localparam int N  = 10;
   localparam int DONE_CYC = 3 + N * (P + 1);   // 653

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       busy, done, img_rd, ref_rd, temp;
   logic [5:0] img_addr;
   logic [9:0] ref_addr;
   logic [7:0] img_data = 8'd0, ref_data = 8'd0, current, reference;
   logic [3:0] index;

   logic       s_start = 1'b0;
   logic       s_busy, s_done, s_img_rd, s_ref_rd, s_temp;
   logic [0:0] s_img_addr, s_ref_addr;
   logic [7:0] s_img_data = 8'd0, s_ref_data = 8'd0, s_current, s_reference;
   logic [3:0] s_index;

   logic [7:0] img_mem [P];
   logic [7:0] ref_mem [N*P];
   logic [7:0] s_img_mem [2];
   logic [7:0] s_ref_mem [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   digit_stream_sequencer dut (
      .clock(clk), .reset(rst), .start(start), .busy(busy), .done(done),
      .img_rd(img_rd), .img_addr(img_addr), .img_data(img_data),
      .ref_rd(ref_rd), .ref_addr(ref_addr), .ref_data(ref_data),
      .current(current), .reference(reference), .temp(temp), .index(index)
   );

   digit_stream_sequencer #(.PIXELS(2), .NUM_REFS(1), .IMG_AW(1), .REF_AW(1)) dut_small (
      .clock(clk), .reset(rst), .start(s_start), .busy(s_busy), .done(s_done),
      .img_rd(s_img_rd), .img_addr(s_img_addr), .img_data(s_img_data),
      .ref_rd(s_ref_rd), .ref_addr(s_ref_addr), .ref_data(s_ref_data),
      .current(s_current), .reference(s_reference), .temp(s_temp), .index(s_index)
   );

   // Synchronous-read RAM models
   always @(posedge clk) begin
      if (img_rd) img_data <= img_mem[img_addr];
      if (ref_rd) ref_data <= ref_mem[ref_addr];
      if (s_img_rd) s_img_data <= s_img_mem[s_img_addr];
      if (s_ref_rd) s_ref_data <= s_ref_mem[s_ref_addr];
   end

   task automatic fill_random(input int match_ref);
      for (int p = 0; p < P; p++) img_mem[p] = 8'($urandom);
      for (int a = 0; a < N*P; a++) ref_mem[a] = 8'($urandom);
      if (match_ref >= 0)
         for (int p = 0; p < P; p++) ref_mem[match_ref*P + p] = img_mem[p];
   endtask

   // One full pass of the default instance, start sampled at edge 0.
   // Cycle c is the period between edge c-1 and edge c; outputs are sampled
   // at the falling edge inside it. Also runs a match-count tracker that
   // keeps the template index with the most equal byte pairs.
   task automatic pass_check(input int pulse_a, input int pulse_b, output int best_idx);
      int sum, best_sum, r, k, ri, ki;
      bit beat, cmp, exp_rd, exp_busy, exp_done, bad_beat, bad_cmp, bad_idle;
      logic [9:0] exp_ra;
      sum = 0; best_sum = -1; best_idx = -1;
      bad_beat = 0; bad_cmp = 0; bad_idle = 0;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int c = 1; c <= DONE_CYC + 4; c++) begin
         @(negedge clk);
         start = (c == pulse_a || c == pulse_b);
         exp_busy = (c <= DONE_CYC);
         exp_done = (c == DONE_CYC);
         ri = (c - 1) / (P + 1); ki = (c - 1) % (P + 1);
         exp_rd = (ri < N) && (ki < P);
         exp_ra = 10'(ri * P + ki);
         r = (c >= 3) ? (c - 3) / (P + 1) : N;
         k = (c >= 3) ? (c - 3) % (P + 1) : 0;
         beat = (r < N) && (k < P);
         cmp  = (r < N) && (k == P);
         checks++;
         if (busy !== exp_busy || done !== exp_done) begin
            errors++;
            $display("FAIL pass_ctl cycle %0d: busy=%b done=%b, required busy=%b done=%b",
                     c, busy, done, exp_busy, exp_done);
         end
         if (exp_rd) begin
            checks++;
            if (img_rd !== 1'b1 || ref_rd !== 1'b1 || img_addr !== 6'(ki) || ref_addr !== exp_ra) begin
               errors++;
               $display("FAIL pass_addr cycle %0d: rd=%b%b img_addr=%0d ref_addr=%0d, required rd=11 img_addr=%0d ref_addr=%0d",
                        c, img_rd, ref_rd, img_addr, ref_addr, ki, exp_ra);
            end
         end else if (img_rd !== 1'b0 || ref_rd !== 1'b0) begin
            checks++; errors++;
            $display("FAIL pass_noread cycle %0d: rd=%b%b, required 00", c, img_rd, ref_rd);
         end
         if (beat) begin
            checks++;
            if (temp !== 1'b1 || current !== img_mem[k] || reference !== ref_mem[r*P + k] || index !== 4'(r)) begin
               errors++;
               if (!bad_beat)
                  $display("FAIL pass_beat cycle %0d: temp=%b cur=%0d ref=%0d idx=%0d, required temp=1 cur=%0d ref=%0d idx=%0d",
                           c, temp, current, reference, index, img_mem[k], ref_mem[r*P + k], r);
               bad_beat = 1;
            end
         end else if (cmp) begin
            checks++;
            if (temp !== 1'b0 || index !== 4'(r)) begin
               errors++;
               if (!bad_cmp)
                  $display("FAIL pass_compare cycle %0d: temp=%b idx=%0d, required temp=0 idx=%0d",
                           c, temp, index, r);
               bad_cmp = 1;
            end
         end else if (temp !== 1'b0) begin
            checks++; errors++;
            if (!bad_idle) $display("FAIL pass_bubble cycle %0d: temp=%b, required 0", c, temp);
            bad_idle = 1;
         end
         if (temp === 1'b1) begin
            if (current === reference) sum++;
         end else if (c >= 3 && c < DONE_CYC) begin
            if (sum > best_sum) begin best_sum = sum; best_idx = int'(index); end
            sum = 0;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy, done, img_rd, ref_rd, temp, img_addr, ref_addr, current, reference, index} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: busy=%b done=%b rd=%b%b temp=%b ia=%0d ra=%0d cur=%0d ref=%0d idx=%0d, required all 0",
                  busy, done, img_rd, ref_rd, temp, img_addr, ref_addr, current, reference, index);
      end
      rst = 1'b0;
      @(negedge clk);
      $display("test_reset done");
   endtask

   task automatic test_match;
      int best;
      fill_random(7);
      pass_check(0, 0, best);
      checks++;
      if (best !== 7) begin
         errors++;
         $display("FAIL match_tracker: best template=%0d, required 7", best);
      end
      $display("test_match best=%0d", best);
   endtask

   task automatic test_ramp;
      int best;
      for (int p = 0; p < P; p++) img_mem[p] = 8'(p);
      for (int rr = 0; rr < N; rr++)
         for (int p = 0; p < P; p++) ref_mem[rr*P + p] = 8'(rr + p);
      pass_check(0, 0, best);
      checks++;
      if (best !== 0) begin
         errors++;
         $display("FAIL ramp_tracker: best template=%0d, required 0", best);
      end
      $display("test_ramp best=%0d", best);
   endtask

   task automatic test_start_busy;
      int best;
      fill_random(3);
      pass_check(100, 400, best);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b0 || done !== 1'b0 || img_rd !== 1'b0) begin
            errors++;
            $display("FAIL start_busy_idle +%0d: busy=%b done=%b rd=%b, required 0 0 0", c, busy, done, img_rd);
         end
      end
      checks++;
      if (best !== 3) begin
         errors++;
         $display("FAIL start_busy_tracker: best=%0d, required 3", best);
      end
      $display("test_start_busy best=%0d", best);
   endtask

   task automatic test_reset_mid;
      int best, done_seen;
      fill_random(5);
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if (c == 200) rst = 1'b1;
      end
      @(negedge clk);
      checks++;
      if ({busy, done, img_rd, ref_rd, temp, img_addr, ref_addr, current, reference, index} !== '0) begin
         errors++;
         $display("FAIL reset_mid_outputs: busy=%b done=%b rd=%b%b temp=%b ia=%0d ra=%0d cur=%0d ref=%0d idx=%0d, required all 0",
                  busy, done, img_rd, ref_rd, temp, img_addr, ref_addr, current, reference, index);
      end
      rst = 1'b0;
      done_seen = 0;
      for (int c = 0; c < 700; c++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) done_seen++;
      end
      checks++;
      if (done_seen != 0) begin
         errors++;
         $display("FAIL reset_mid_nodone: %0d cycles with busy/done, required 0", done_seen);
      end
      pass_check(0, 0, best);
      checks++;
      if (best !== 5) begin
         errors++;
         $display("FAIL reset_mid_tracker: best=%0d, required 5", best);
      end
      $display("test_reset_mid best=%0d", best);
   endtask

   task automatic test_small;
      bit eb, ed, et;
      s_img_mem[0] = 8'($urandom); s_img_mem[1] = 8'($urandom);
      s_ref_mem[0] = 8'($urandom); s_ref_mem[1] = 8'($urandom);
      @(negedge clk); s_start = 1'b1;
      @(posedge clk); #1 s_start = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         eb = (c >= 1 && c <= 6);
         ed = (c == 6);
         et = (c == 3 || c == 4);
         checks++;
         if (s_busy !== eb || s_done !== ed || s_temp !== et) begin
            errors++;
            $display("FAIL small_ctl cycle %0d: busy=%b done=%b temp=%b, required %b %b %b",
                     c, s_busy, s_done, s_temp, eb, ed, et);
         end
         if (et) begin
            checks++;
            if (s_current !== s_img_mem[c-3] || s_reference !== s_ref_mem[c-3] || s_index !== 4'd0) begin
               errors++;
               $display("FAIL small_beat cycle %0d: cur=%0d ref=%0d idx=%0d, required %0d %0d 0",
                        c, s_current, s_reference, s_index, s_img_mem[c-3], s_ref_mem[c-3]);
            end
         end
         if (c == 5) begin
            checks++;
            if (s_index !== 4'd0) begin
               errors++;
               $display("FAIL small_compare_index: idx=%0d, required 0", s_index);
            end
         end
      end
      $display("test_small done");
   endtask

   task automatic test_back_to_back;
      int c, first_done, second_done;
      fill_random(-1);
      first_done = -1; second_done = -1;
      @(negedge clk); start = 1'b1;
      @(posedge clk);
      c = 0;
      while (c < 2 * DONE_CYC + 20 && second_done < 0) begin
         c++;
         @(negedge clk);
         if (done === 1'b1) begin
            if (first_done < 0) first_done = c;
            else second_done = c;
         end
         if (c == DONE_CYC + 1) begin
            checks++;
            if (img_rd !== 1'b1 || img_addr !== 6'd0 || ref_addr !== 10'd0 || busy !== 1'b1) begin
               errors++;
               $display("FAIL b2b_restart cycle %0d: rd=%b ia=%0d ra=%0d busy=%b, required 1 0 0 1",
                        c, img_rd, img_addr, ref_addr, busy);
            end
            start = 1'b0;
         end
      end
      start = 1'b0;
      checks++;
      if (first_done != DONE_CYC || second_done != 2 * DONE_CYC) begin
         errors++;
         $display("FAIL b2b_done_cycles: first=%0d second=%0d, required %0d %0d",
                  first_done, second_done, DONE_CYC, 2 * DONE_CYC);
      end
      $display("test_back_to_back done at %0d and %0d", first_done, second_done);
   endtask

   initial begin
      test_reset();
      test_match();
      test_ramp();
      test_start_busy();
      test_reset_mid();
      test_small();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
